// File: rtl/wb_trace_fifo.sv
// wb_trace_fifo: writeback trace capture buffer.
// Every retired register write (wb_e/wb_a/wb_d) is stamped with a free-running
// cycle counter and queued in a circular buffer, drained over a valid/ready
// stream. The pipeline is never stalled: pushes into a full buffer are dropped,
// counted (saturating) and flagged via a sticky overflow bit.
// Optional build macro: WB_TRACE_X0_FILTER_EN -- when defined, writes to x0
// are ignored (not stored, not counted as drops).
module wb_trace_fifo #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wb_e,
  input  logic [4:0]               wb_a,
  input  logic [31:0]              wb_d,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [4:0]               out_addr,
  output logic [31:0]              out_data,
  output logic [TS_W-1:0]          out_ts,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               drop_cnt,
  input  logic                     clr_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]      addr;
    logic [31:0]     data;
    logic [TS_W-1:0] ts;
  } entry_t;

  entry_t          mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [AW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic push_req, full, do_push, do_pop, drop;
  entry_t head;

  // Capture qualification, optionally filtering x0 writes.
`ifdef WB_TRACE_X0_FILTER_EN
  assign push_req = wb_e && (wb_a != 5'd0);
`else
  assign push_req = wb_e;
`endif

  assign full    = (count_q == FULL_CNT);
  assign do_pop  = out_valid && out_ready;
  // A push while full only fits if the head leaves on the same edge.
  assign do_push = push_req && (!full || do_pop);
  assign drop    = push_req && full && !do_pop;

  // Next-state for pointers, occupancy, timestamp and overflow tracking.
  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    ts_d       = ts_q + TS_W'(1);
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;

    if (do_push) wptr_d = wptr_q + AW'(1);
    if (do_pop)  rptr_d = rptr_q + AW'(1);

    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A drop on the same edge as a clear wins: the new drop is the first one.
    if (drop) begin
      overflow_d = 1'b1;
      if (clr_overflow)              drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF)  drop_cnt_d = drop_cnt_q + 8'd1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
      drop_cnt_d = 8'd0;
    end
  end

  // Control state register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= '{addr: wb_a, data: wb_d, ts: ts_q};
  end

  // Head read through the registered read pointer, zeroed when empty.
  always_comb begin
    head      = mem_q[rptr_q];
    out_valid = (count_q != '0);
    out_addr  = out_valid ? head.addr : 5'd0;
    out_data  = out_valid ? head.data : 32'd0;
    out_ts    = out_valid ? head.ts   : '0;
  end

  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_wb_trace_fifo.sv
// Bench for wb_trace_fifo: directed stimulus pushes expected head entries into
// a queue; a negedge monitor pops and compares whenever a pop handshake occurs.
module tb_wb_trace_fifo;
  localparam int DEPTH = 8;
  localparam int TS_W  = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        wb_e = 1'b0;
  logic [4:0]  wb_a = '0;
  logic [31:0] wb_d = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_addr;
  logic [31:0] out_data;
  logic [TS_W-1:0] out_ts;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;
  logic        clr_overflow = 1'b0;

  wb_trace_fifo #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk(clk), .reset(reset), .wb_e(wb_e), .wb_a(wb_a), .wb_d(wb_d),
    .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
    .out_data(out_data), .out_ts(out_ts), .count(count), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_overflow(clr_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]      a;
    logic [31:0]     d;
    logic [TS_W-1:0] ts;
  } exp_t;

  exp_t expq[$];
  int passed = 0;
  int total  = 0;
  logic [TS_W-1:0] tb_ts;

  // Cycles elapsed since reset release: the timestamp the next edge captures.
  always @(posedge clk or negedge reset)
    if (!reset) tb_ts <= '0;
    else        tb_ts <= tb_ts + 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Monitor: every pop handshake must match the oldest expected entry.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        chk("unexpected_pop", 64'(out_addr), 64'hFFFF);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("pop_addr", 64'(out_addr), 64'(e.a));
        chk("pop_data", 64'(out_data), 64'(e.d));
        chk("pop_ts",   64'(out_ts),   64'(e.ts));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write; acc says whether the design should store it.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input bit acc);
    wb_e = 1'b1; wb_a = a; wb_d = d;
    if (acc) expq.push_back('{a: a, d: d, ts: tb_ts});
    step();
    wb_e = 1'b0;
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    repeat (n) step();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid",    64'(out_valid), 64'd0);
    chk("rst_count",    64'(count),     64'd0);
    chk("rst_overflow", 64'(overflow),  64'd0);
    chk("rst_drop",     64'(drop_cnt),  64'd0);
    chk("rst_head",     {out_addr, out_data, out_ts}, 64'd0);
    reset = 1'b1;

    // Single capture at ts=5.
    repeat (5) step();
    wr(5'd1, 32'hDEADBEEF, 1);
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_count", 64'(count),     64'd1);
    chk("t1_ts",    64'(out_ts),    64'd5);
    chk("t1_data",  64'(out_data),  64'hDEADBEEF);
    drain(1);
    chk("t1_empty", 64'(count), 64'd0);

    // Back-to-back writes held, then drained in order.
    wr(5'd1, 32'hDEADBEEF, 1);
    wr(5'd2, 32'h12345678, 1);
    wr(5'd7, 32'h00000004, 1);
    wr(5'd3, 32'hFEDCBA98, 1);
    chk("t2_count4", 64'(count), 64'd4);
    drain(4);
    chk("t2_count0", 64'(count),     64'd0);
    chk("t2_valid0", 64'(out_valid), 64'd0);

    // Overflow: 10 writes into 8 entries.
    for (int i = 0; i < 10; i++) wr(5'(i + 8), 32'h100 + 32'(i), i < DEPTH);
    chk("ovf_count", 64'(count),    64'd8);
    chk("ovf_flag",  64'(overflow), 64'd1);
    chk("ovf_drop",  64'(drop_cnt), 64'd2);
    clr_overflow = 1'b1; step(); clr_overflow = 1'b0;
    chk("clr_flag",  64'(overflow), 64'd0);
    chk("clr_drop",  64'(drop_cnt), 64'd0);
    chk("clr_count", 64'(count),    64'd8);

    // Full with simultaneous push and pop: accepted, count holds.
    out_ready = 1'b1;
    wr(5'd9, 32'hA5A5A5A5, 1);
    out_ready = 1'b0;
    chk("fpp_count", 64'(count),    64'd8);
    chk("fpp_flag",  64'(overflow), 64'd0);

    // Drop saturation.
    for (int i = 0; i < 300; i++) wr(5'd4, 32'(i), 0);
    chk("sat_drop",  64'(drop_cnt), 64'd255);
    chk("sat_count", 64'(count),    64'd8);

    // Clear and drop on the same edge: drop wins.
    clr_overflow = 1'b1;
    wr(5'd5, 32'h5, 0);
    clr_overflow = 1'b0;
    chk("clrdrop_flag", 64'(overflow), 64'd1);
    chk("clrdrop_cnt",  64'(drop_cnt), 64'd1);
    drain(8);
    chk("drain_count", 64'(count), 64'd0);

    // x0 write.
`ifdef WB_TRACE_X0_FILTER_EN
    wr(5'd0, 32'h55, 0);
    chk("x0_count", 64'(count), 64'd0);
`else
    wr(5'd0, 32'h55, 1);
    chk("x0_count", 64'(count),    64'd1);
    chk("x0_addr",  64'(out_addr), 64'd0);
    drain(1);
`endif

    // Async reset with 3 entries queued.
    wr(5'd10, 32'hA, 1);
    wr(5'd11, 32'hB, 1);
    wr(5'd12, 32'hC, 1);
    chk("pre_rst_count", 64'(count), 64'd3);
    #2 reset = 1'b0;
    #1;
    chk("arst_valid",    64'(out_valid), 64'd0);
    chk("arst_count",    64'(count),     64'd0);
    chk("arst_overflow", 64'(overflow),  64'd0);
    chk("arst_drop",     64'(drop_cnt),  64'd0);
    expq.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) step();
    wr(5'd4, 32'h44, 1);
    chk("post_rst_ts",    64'(out_ts),   64'd3);
    chk("post_rst_count", 64'(count),    64'd1);
    drain(1);

    chk("queue_empty", 64'(expq.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
